// File: rtl/alu_pkg.sv
// alu_pkg: ALU select encodings, function codes and issue FSM states
package alu_pkg;
  localparam logic [2:0] SEL_ADD = 3'b000;
  localparam logic [2:0] SEL_SUB = 3'b010;
  localparam logic [2:0] SEL_OR  = 3'b011;
  localparam logic [2:0] SEL_AND = 3'b100;
  localparam logic [2:0] SEL_SLT = 3'b101;
  localparam logic [2:0] SEL_MUL = 3'b110;
  localparam logic [2:0] SEL_NOP = 3'b111;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_MUL = 6'h18;
  localparam logic [5:0] FN_NOP = 6'h00;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/alu_funct_decode.sv
// alu_funct_decode: maps a function code to an ALU select, flagging unknown codes
module alu_funct_decode
  import alu_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] sel,
  output logic       err
);
  always_comb begin
    sel = funct == FN_ADD ? SEL_ADD :
          funct == FN_SUB ? SEL_SUB :
          funct == FN_OR  ? SEL_OR  :
          funct == FN_AND ? SEL_AND :
          funct == FN_SLT ? SEL_SLT :
          funct == FN_MUL ? SEL_MUL : SEL_NOP;
    err = sel == SEL_NOP && funct != FN_NOP;
  end
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one request at a time to an external ALU and holds its response
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [5:0]       req_funct,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [2:0]       alu_sel,
  output logic [WIDTH-1:0] alu_op1,
  output logic [WIDTH-1:0] alu_op2,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_zf,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_res,
  output logic             rsp_zf,
  output logic             rsp_err,
  output logic [CNT_W-1:0] op_count
);
  state_t           state, state_n;
  logic [2:0]       dec_sel, sel_q;
  logic             dec_err, err_q, accept;
  logic [WIDTH-1:0] a_q, b_q;
  alu_funct_decode u_dec (.funct(req_funct), .sel(dec_sel), .err(dec_err));
  always_comb begin
    req_ready = state == IDLE || (state == RESP && rsp_ready);
    accept    = req_valid && req_ready;
    rsp_valid = state == RESP;
    alu_sel   = state == EXEC ? sel_q : SEL_NOP;
    alu_op1   = state == EXEC ? a_q : '0;
    alu_op2   = state == EXEC ? b_q : '0;
    state_n   = state == IDLE ? (accept ? EXEC : IDLE) :
                state == EXEC ? RESP :
                rsp_ready ? (req_valid ? EXEC : IDLE) : RESP;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q    <= SEL_NOP;
      err_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      rsp_res  <= '0;
      rsp_zf   <= 1'b0;
      rsp_err  <= 1'b0;
      op_count <= '0;
    end else begin
      if (accept) begin
        sel_q <= dec_sel;
        err_q <= dec_err;
        a_q   <= req_a;
        b_q   <= req_b;
      end
      // illegal codes report the nop result regardless of what the ALU returns
      if (state == EXEC) begin
        rsp_res <= err_q ? '0 : alu_res;
        rsp_zf  <= err_q | alu_zf;
        rsp_err <= err_q;
      end
      if (rsp_valid && rsp_ready) op_count <= op_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed scoreboard bench with a behavioural ALU beside the DUT
module tb_alu_issue_ctrl;
  localparam int W = 32;
  typedef struct { logic [W-1:0] res; logic zf; logic err; } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, rsp_ready = 1'b0;
  logic [5:0] req_funct = '0;
  logic [W-1:0] req_a = '0, req_b = '0, alu_op1, alu_op2, alu_res, rsp_res;
  logic [2:0] alu_sel;
  logic req_ready, alu_zf, rsp_valid, rsp_zf, rsp_err;
  logic [15:0] op_count;
  logic w_req_ready, w_rsp_valid, w_rsp_zf, w_rsp_err;
  logic [2:0] w_alu_sel;
  logic [W-1:0] w_op1, w_op2, w_rsp_res;
  logic [3:0] w_op_count;
  exp_t sbq[$];
  exp_t last;
  int n_vec = 0, n_err = 0, exp_cnt = 0;
  always #5 clk = ~clk;
  alu_issue_ctrl #(.WIDTH(W), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_funct(req_funct), .req_a(req_a), .req_b(req_b), .alu_sel(alu_sel),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_res(alu_res), .alu_zf(alu_zf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res),
    .rsp_zf(rsp_zf), .rsp_err(rsp_err), .op_count(op_count));
  alu_issue_ctrl #(.WIDTH(W), .CNT_W(4)) u_wrap (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(w_req_ready),
    .req_funct(req_funct), .req_a(req_a), .req_b(req_b), .alu_sel(w_alu_sel),
    .alu_op1(w_op1), .alu_op2(w_op2), .alu_res(alu_res), .alu_zf(alu_zf),
    .rsp_valid(w_rsp_valid), .rsp_ready(rsp_ready), .rsp_res(w_rsp_res),
    .rsp_zf(w_rsp_zf), .rsp_err(w_rsp_err), .op_count(w_op_count));
  always_comb begin
    case (alu_sel)
      3'b000:  alu_res = alu_op1 + alu_op2;
      3'b010:  alu_res = alu_op1 - alu_op2;
      3'b011:  alu_res = alu_op1 | alu_op2;
      3'b100:  alu_res = alu_op1 & alu_op2;
      3'b101:  alu_res = {{(W-1){1'b0}}, alu_op1 < alu_op2};
      3'b110:  alu_res = alu_op1 * alu_op2;
      default: alu_res = '0;
    endcase
    alu_zf = alu_res == '0;
  end
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check_rsp;
    if (sbq.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL sb_empty: observed response with no expected entry");
    end else begin
      last = sbq.pop_front();
      chk("rsp_res", rsp_res, last.res);
      chk("rsp_zf", {31'b0, rsp_zf}, {31'b0, last.zf});
      chk("rsp_err", {31'b0, rsp_err}, {31'b0, last.err});
    end
  endtask
  task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] sel, input logic [W-1:0] res, input logic zf, input logic err);
    req_valid = 1'b1; req_funct = f; req_a = a; req_b = b;
    sbq.push_back('{res, zf, err});
    chk("idle_ready", {31'b0, req_ready}, 1);
    tick;
    req_valid = 1'b0;
    chk("exec_sel", {29'b0, alu_sel}, {29'b0, sel});
    chk("exec_op1", alu_op1, a);
    chk("exec_op2", alu_op2, b);
    chk("exec_no_valid", {31'b0, rsp_valid}, 0);
    chk("exec_no_ready", {31'b0, req_ready}, 0);
    tick;
    chk("rsp_valid_lat", {31'b0, rsp_valid}, 1);
    chk("resp_idle_sel", {29'b0, alu_sel}, 7);
    check_rsp();
  endtask
  task automatic drain(input int hold);
    rsp_ready = 1'b0;
    repeat (hold) begin
      tick;
      chk("hold_valid", {31'b0, rsp_valid}, 1);
      chk("hold_res", rsp_res, last.res);
      chk("hold_zf", {31'b0, rsp_zf}, {31'b0, last.zf});
      chk("hold_cnt", {16'b0, op_count}, exp_cnt);
      chk("hold_no_ready", {31'b0, req_ready}, 0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("resp_ready_pass", {31'b0, req_ready}, 1);
    tick;
    exp_cnt++;
    rsp_ready = 1'b0;
    chk("cnt_after_hs", {16'b0, op_count}, exp_cnt);
    chk("idle_no_valid", {31'b0, rsp_valid}, 0);
    chk("idle_op1", alu_op1, 0);
  endtask
  initial begin
    repeat (2) tick;
    chk("rst_valid", {31'b0, rsp_valid}, 0);
    chk("rst_sel", {29'b0, alu_sel}, 7);
    chk("rst_op1", alu_op1, 0);
    chk("rst_op2", alu_op2, 0);
    chk("rst_res", rsp_res, 0);
    chk("rst_flags", {30'b0, rsp_zf, rsp_err}, 0);
    chk("rst_cnt", {16'b0, op_count}, 0);
    rst_n = 1'b1;
    tick;
    chk("rst_ready", {31'b0, req_ready}, 1);
    issue(6'h20, 5, 7, 3'b000, 12, 1'b0, 1'b0);
    drain(0);
    issue(6'h22, 32'h1234, 32'h1234, 3'b010, 0, 1'b1, 1'b0);
    drain(3);
    issue(6'h25, 32'hF0, 32'h0F, 3'b011, 32'hFF, 1'b0, 1'b0);
    drain(1);
    issue(6'h24, 32'hFF00, 32'h0FF0, 3'b100, 32'h0F00, 1'b0, 1'b0);
    drain(0);
    issue(6'h2A, 9, 3, 3'b101, 0, 1'b1, 1'b0);
    drain(0);
    issue(6'h2A, 32'h1, 32'hFFFF_FFFF, 3'b101, 1, 1'b0, 1'b0);
    drain(0);
    issue(6'h00, 32'hAB, 32'hCD, 3'b111, 0, 1'b1, 1'b0);
    drain(0);
    issue(6'h3F, 32'h55, 32'h66, 3'b111, 0, 1'b1, 1'b1);
    drain(1);
    rsp_ready = 1'b1; req_valid = 1'b1; req_funct = 6'h2A; req_a = 3; req_b = 9;
    sbq.push_back('{32'd1, 1'b0, 1'b0});
    tick;
    chk("b2b_sel_slt", {29'b0, alu_sel}, 5);
    chk("b2b_exec_no_ready", {31'b0, req_ready}, 0);
    req_funct = 6'h18; req_a = 32'h10000; req_b = 32'h10000;
    sbq.push_back('{32'd0, 1'b1, 1'b0});
    tick;
    chk("b2b_valid1", {31'b0, rsp_valid}, 1);
    check_rsp();
    chk("b2b_ready", {31'b0, req_ready}, 1);
    tick;
    exp_cnt++;
    req_valid = 1'b0;
    chk("b2b_cnt1", {16'b0, op_count}, exp_cnt);
    chk("b2b_sel_mul", {29'b0, alu_sel}, 6);
    chk("b2b_no_valid", {31'b0, rsp_valid}, 0);
    tick;
    chk("b2b_valid2", {31'b0, rsp_valid}, 1);
    check_rsp();
    tick;
    exp_cnt++;
    rsp_ready = 1'b0;
    chk("b2b_cnt2", {16'b0, op_count}, exp_cnt);
    chk("b2b_idle", {31'b0, rsp_valid}, 0);
    req_valid = 1'b1; req_funct = 6'h20; req_a = 1; req_b = 2;
    tick;
    req_valid = 1'b0;
    chk("pre_rst_exec", {29'b0, alu_sel}, 0);
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    chk("mid_rst_sel", {29'b0, alu_sel}, 7);
    chk("mid_rst_op1", alu_op1, 0);
    chk("mid_rst_valid", {31'b0, rsp_valid}, 0);
    chk("mid_rst_cnt", {16'b0, op_count}, 0);
    chk("mid_rst_zf", {31'b0, rsp_zf}, 0);
    tick;
    rst_n = 1'b1;
    repeat (3) begin
      tick;
      chk("post_rst_no_valid", {31'b0, rsp_valid}, 0);
    end
    rsp_ready = 1'b1; req_valid = 1'b1; req_funct = 6'h20; req_a = 1; req_b = 1;
    tick;
    for (int k = 1; k <= 17; k++) begin
      tick;
      tick;
      exp_cnt++;
      chk("wrap_small_cnt", {28'b0, w_op_count}, exp_cnt % 16);
      chk("wrap_main_cnt", {16'b0, op_count}, exp_cnt);
      chk("wrap_res", rsp_res, 2);
    end
    req_valid = 1'b0;
    repeat (2) tick;
    rsp_ready = 1'b0;
    exp_cnt++;
    chk("final_cnt", {16'b0, op_count}, exp_cnt);
    chk("final_small_cnt", {28'b0, w_op_count}, exp_cnt % 16);
    chk("sb_drained", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; matches the ALU datapath.
REQ-002 Parameter: CNT_W, 16, width of completed-operation counter.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: req_valid  input  1  request present.
REQ-006 Port: req_ready  output  1  request accepted when req_valid && req_ready at clk edge.
REQ-007 Port: req_funct  input  6  function code.
REQ-008 Port: req_a, req_b  input  WIDTH  operands.
REQ-009 Port: alu_sel  output  3  ALU operation select.
REQ-010 Port: alu_op1, alu_op2  output  WIDTH  ALU operands.
REQ-011 Port: alu_res  input  WIDTH  ALU result (combinational from alu_sel/op1/op2).
REQ-012 Port: alu_zf  input  1  ALU zero flag.
REQ-013 Port: rsp_valid  output  1  response held until rsp_valid && rsp_ready.
REQ-014 Port: rsp_ready  input  1  consumer ready.
REQ-015 Port: rsp_res  output  WIDTH  captured result.
REQ-016 Port: rsp_zf  output  1  captured zero flag.
REQ-017 Port: rsp_err  output  1  request carried an illegal funct.
REQ-018 Port: op_count  output  CNT_W  completed responses, wraps modulo 2^CNT_W.

Function
REQ-019 The block SHALL decode funct: 0x20 add->000, 0x22 sub->010, 0x25 or->011, 0x24 and->100, 0x2A slt->101, 0x18 mul->110, 0x00 nop->111; any other code is illegal -> sel 111, err=1.
REQ-020 FSM states SHALL be IDLE, EXEC, RESP; reset state IDLE.
REQ-021 IDLE: req_ready=1; on accept, register decoded sel, err, req_a, req_b; go EXEC.
REQ-022 EXEC: drive alu_sel/alu_op1/alu_op2 from registers; at end of the single EXEC cycle capture alu_res, alu_zf, err into rsp registers; go RESP.
REQ-023 Latency: rsp_valid SHALL rise exactly 2 edges after the accepting edge (accept edge N, capture edge N+1, rsp_valid visible after N+1).
REQ-024 RESP: rsp_valid=1; rsp_res/rsp_zf/rsp_err SHALL stay stable while rsp_ready=0.
REQ-025 RESP with rsp_ready=1 and req_valid=0: go IDLE; with rsp_ready=1 and req_valid=1: accept new request same edge, go EXEC (req_ready = IDLE || (RESP && rsp_ready)).
REQ-026 op_count SHALL increment by 1 on each rsp_valid && rsp_ready edge, wrapping from all-ones to 0.
REQ-027 Illegal funct SHALL complete normally with rsp_err=1, rsp_res=0, rsp_zf=1 (ALU nop result), and count toward op_count.
REQ-028 Arithmetic SHALL be the ALU's: results truncated to WIDTH, slt unsigned, mul low WIDTH bits; the block adds no arithmetic.
REQ-029 Outside EXEC, alu_sel SHALL be 111 and alu_op1/alu_op2 SHALL be 0.
REQ-030 req_ready SHALL be 0 in EXEC and in RESP while rsp_ready=0.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, req_ready=1 (after release), rsp_valid=0, rsp_res=0, rsp_zf=0, rsp_err=0, op_count=0, alu_sel=111, alu_op1=alu_op2=0, all captured registers 0.
REQ-032 Reset mid-operation (EXEC or RESP) SHALL discard the in-flight request; no response is produced after release.

Structure
REQ-033 Package alu_pkg SHALL hold the 3-bit sel encodings, 6-bit funct constants, and the FSM state enumeration.
REQ-034 Funct-to-sel/err decode SHALL be a combinational sub-module alu_funct_decode, instantiated once.
REQ-035 The ALU itself SHALL NOT be instantiated inside this block; it connects at the level above.

Verification
REQ-036 add: funct 0x20, a=5, b=7 -> rsp_valid 2 edges after accept, rsp_res=12, rsp_zf=0, rsp_err=0.
REQ-037 sub to zero: funct 0x22, a=b=0x1234 -> rsp_res=0, rsp_zf=1; rsp held 3 cycles with rsp_ready=0, values stable, op_count increments only on final handshake.
REQ-038 Back-to-back: rsp_ready=1, req_valid held for slt (a=3,b=9) then mul (a=0x10000,b=0x10000) -> res 1 then 0 with zf=1; one request accepted every 2 cycles.
REQ-039 Illegal funct 0x3F -> rsp_err=1, rsp_res=0, rsp_zf=1, op_count+1.
REQ-040 Reset asserted during EXEC -> outputs at reset values immediately, no rsp_valid after release; op_count wraps 0xFFFF->0 after preload by 65536 handshakes.
